ppe_rr_encoder_pipe: RTL and testbench

Pipelined programmable priority encoder, generalised from the flat 1024-to-10 combinational encoder. It takes an N-bit request vector and returns the index of the first set bit at or above a programmable priority pointer, wrapping to bit 0 if none is found above it. The pointer is software-loaded, or auto-advances round-robin after each delivered grant. It sits between request aggregation and the arbiter grant logic, with valid/ready handshakes on both sides.

---
 rtl/ppe_pkg.sv | 17 +
 rtl/ppe_fixed_encoder.sv | 26 ++
 rtl/ppe_rr_encoder_pipe.sv | 136 +++++++++++++
 tb/tb_ppe_rr_encoder_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppe_pkg.sv
// ppe_pkg -- shared definitions for the pipelined programmable priority encoder.
//   ppe_idx_width : index/pointer width for an N-entry request vector (min 1 bit)
//   PPE_LATENCY   : cycles from input fire to out_valid with no stalls
//   ppe_wrap_inc  : modular pointer increment, (idx + 1) mod n
package ppe_pkg;

  localparam int PPE_LATENCY = 2;

  function automatic int ppe_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ppe_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ppe_fixed_encoder.sv
// ppe_fixed_encoder -- combinational lowest-index-first priority encoder.
//   req : N-bit request vector
//   idx : index of the lowest set bit of req (0 when req is all-zero)
//   any : at least one bit of req is set
module ppe_fixed_encoder
  import ppe_pkg::*;
#(
  parameter  int N = 1024,
  localparam int W = ppe_idx_width(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/ppe_rr_encoder_pipe.sv
// ppe_rr_encoder_pipe -- two-stage pipelined programmable (round-robin) priority
// encoder. Returns the first set request at or above the pointer, wrapping to
// the lowest set request below it.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake for in_req
//   in_req[N-1:0]       : request vector
//   out_valid/out_ready : downstream handshake for out_idx/out_none
//   out_idx[W-1:0]      : granted index (0 when out_none)
//   out_none            : the captured request vector was all-zero
//   cfg_we, cfg_ptr     : load a new pointer value on the next edge
//   cfg_auto            : advance the pointer past each delivered grant
//   ptr                 : current pointer value
module ppe_rr_encoder_pipe
  import ppe_pkg::*;
#(
  parameter  int N = 1024,
  localparam int W = ppe_idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_ptr,
  input  logic         cfg_auto,
  output logic [W-1:0] ptr
);

  // Stage 1 (capture) registers
  logic         r_s1_valid;
  logic [N-1:0] r_s1_hi;
  logic [N-1:0] r_s1_lo;
  logic         r_s1_none;

  // Output stage registers
  logic         r_out_valid;
  logic [W-1:0] r_out_idx;
  logic         r_out_none;

  logic [W-1:0] r_ptr;

  logic         w_out_adv;
  logic         w_out_fire;
  logic         w_in_fire;
  logic [W-1:0] w_ptr_eff;
  logic [N-1:0] w_hi;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;
  logic         w_hi_any;
  logic         w_lo_any;
  logic [W-1:0] w_enc_idx;

  // The output stage can take a new entry when it is empty or draining this
  // cycle; stage 1 moves exactly when the output stage does.
  assign w_out_adv  = !r_out_valid || out_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign in_ready   = !r_s1_valid || w_out_adv;
  assign w_in_fire  = in_valid && in_ready;

  // Pointer values beyond the last requester (non-power-of-2 N) select bit 0.
  assign w_ptr_eff = (int'(r_ptr) >= N) ? '0 : r_ptr;

  // Thermometer mask: keep only requests at or above the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign w_hi[gi] = in_req[gi] & (gi >= int'(w_ptr_eff));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hi    <= '0;
      r_s1_lo    <= '0;
      r_s1_none  <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_hi   <= w_hi;
        r_s1_lo   <= in_req;
        r_s1_none <= ~|in_req;
      end
    end
  end

  ppe_fixed_encoder #(.N(N)) u_enc_hi (
    .req (r_s1_hi),
    .idx (w_hi_idx),
    .any (w_hi_any)
  );

  ppe_fixed_encoder #(.N(N)) u_enc_lo (
    .req (r_s1_lo),
    .idx (w_lo_idx),
    .any (w_lo_any)
  );

  // Nothing at or above the pointer means the search wraps to the bottom.
  // An all-zero vector leaves w_lo_idx at 0, which is the required out_idx.
  assign w_enc_idx = w_hi_any ? w_hi_idx : w_lo_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_none  <= 1'b0;
    end else if (w_out_adv) begin
      r_out_valid <= r_s1_valid;
      // Only overwrite the payload when a real entry arrives.
      if (r_s1_valid) begin
        r_out_idx  <= w_enc_idx;
        r_out_none <= r_s1_none || !w_lo_any;
      end
    end
  end

  // Software load takes precedence over the round-robin advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (cfg_we) begin
      r_ptr <= cfg_ptr;
    end else if (w_out_fire && cfg_auto && !r_out_none) begin
      r_ptr <= W'(ppe_wrap_inc(int'(r_out_idx), N));
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_none  = r_out_none;
  assign ptr       = r_ptr;

endmodule

// File: tb/tb_ppe_rr_encoder_pipe.sv
module tb_ppe_rr_encoder_pipe;
  import ppe_pkg::*;

  localparam int NI = 3;

  function automatic int n_of(input int k);
    case (k)
      0:       return 8;
      1:       return 1024;
      default: return 6;
    endcase
  endfunction

  typedef struct {
    logic [9:0] idx;
    logic       none;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [NI-1:0]        in_valid_v;
  logic [NI-1:0]        in_ready_v;
  logic [NI-1:0][1023:0] in_req_v;
  logic [NI-1:0]        out_valid_v;
  logic [NI-1:0]        out_ready_v;
  logic [NI-1:0][9:0]   out_idx_v;
  logic [NI-1:0]        out_none_v;
  logic [NI-1:0]        cfg_we_v;
  logic [NI-1:0][9:0]   cfg_ptr_v;
  logic [NI-1:0]        cfg_auto_v;
  logic [NI-1:0][9:0]   ptr_v;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q [NI][$];
  int   mptr [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int NN = n_of(gi);
    localparam int WW = ppe_idx_width(NN);
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_out_none;
    logic [WW-1:0] w_idx;
    logic [WW-1:0] w_ptr;

    ppe_rr_encoder_pipe #(.N(NN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (w_in_ready),
      .in_req    (in_req_v[gi][NN-1:0]),
      .out_valid (w_out_valid),
      .out_ready (out_ready_v[gi]),
      .out_idx   (w_idx),
      .out_none  (w_out_none),
      .cfg_we    (cfg_we_v[gi]),
      .cfg_ptr   (cfg_ptr_v[gi][WW-1:0]),
      .cfg_auto  (cfg_auto_v[gi]),
      .ptr       (w_ptr)
    );

    assign in_ready_v[gi]  = w_in_ready;
    assign out_valid_v[gi] = w_out_valid;
    assign out_none_v[gi]  = w_out_none;
    assign out_idx_v[gi]   = 10'(w_idx);
    assign ptr_v[gi]       = 10'(w_ptr);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: first set bit at or above p (p out of range means 0), else lowest.
  function automatic exp_t model(input logic [1023:0] r, input int n, input int p);
    exp_t e;
    int   start;
    e.idx  = '0;
    e.none = 1'b1;
    start  = (p >= n) ? 0 : p;
    for (int i = start; i < n; i++) begin
      if (r[i] && e.none) begin
        e.idx  = 10'(i);
        e.none = 1'b0;
      end
    end
    for (int i = 0; i < start; i++) begin
      if (r[i] && e.none) begin
        e.idx  = 10'(i);
        e.none = 1'b0;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: samples on the falling edge, predicts what the next
  // rising edge does to the pointer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < NI; k++) begin
          sb_q[k].delete();
          mptr[k] = 0;
        end
      end else begin
        for (int k = 0; k < NI; k++) begin
          exp_t e;
          int   nxt;
          chk_val($sformatf("ptr[%0d]", k), 32'(ptr_v[k]), 32'(mptr[k]));
          nxt = mptr[k];
          if (out_valid_v[k]) begin
            if (sb_q[k].size() == 0) begin
              chk_val($sformatf("spurious_valid[%0d]", k), 32'(out_valid_v[k]), 32'd0);
            end else begin
              e = sb_q[k][0];
              chk_val($sformatf("out_idx[%0d]", k), 32'(out_idx_v[k]), 32'(e.idx));
              chk_val($sformatf("out_none[%0d]", k), 32'(out_none_v[k]), 32'(e.none));
              if (out_ready_v[k]) begin
                void'(sb_q[k].pop_front());
                $display("inst %0d grant idx=%0d none=%0d ptr=%0d", k, out_idx_v[k],
                         out_none_v[k], ptr_v[k]);
                if (cfg_auto_v[k] && !e.none)
                  nxt = (int'(e.idx) + 1 == n_of(k)) ? 0 : int'(e.idx) + 1;
              end
            end
          end
          if (in_valid_v[k] && in_ready_v[k])
            sb_q[k].push_back(model(in_req_v[k], n_of(k), mptr[k]));
          if (cfg_we_v[k]) nxt = int'(cfg_ptr_v[k]);
          mptr[k] = nxt;
        end
      end
    end
  end

  task automatic wait_accept(input int k);
    logic acc;
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready_v[k];
      @(posedge clk);
      #1;
    end
    in_valid_v[k] = 1'b0;
    chk_val($sformatf("accept[%0d]", k), 32'(acc), 32'd1);
  endtask

  task automatic send(input int k, input logic [1023:0] r);
    in_valid_v[k] = 1'b1;
    in_req_v[k]   = r;
    wait_accept(k);
  endtask

  task automatic set_ptr(input int k, input int p);
    cfg_we_v[k]  = 1'b1;
    cfg_ptr_v[k] = 10'(p);
    @(posedge clk);
    #1;
    cfg_we_v[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int c = 0; c < 20 && (sb_q[k].size() != 0 || out_valid_v[k]); c++) begin
      @(posedge clk);
      #1;
    end
    chk_val($sformatf("drained[%0d]", k), 32'(sb_q[k].size()), 32'd0);
  endtask

  // Checks out_valid stays low for PPE_LATENCY-1 sampled cycles, then rises.
  task automatic check_latency(input int k);
    for (int c = 1; c < PPE_LATENCY; c++) begin
      @(negedge clk);
      chk_val($sformatf("lat_early[%0d]", k), 32'(out_valid_v[k]), 32'd0);
    end
    @(negedge clk);
    chk_val($sformatf("lat_valid[%0d]", k), 32'(out_valid_v[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] r;
    rst         = 1'b1;
    in_valid_v  = '0;
    in_req_v    = '0;
    out_ready_v = '1;
    cfg_we_v    = '0;
    cfg_ptr_v   = '0;
    cfg_auto_v  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk_val($sformatf("rst_valid[%0d]", k), 32'(out_valid_v[k]), 32'd0);
      chk_val($sformatf("rst_idx[%0d]", k), 32'(out_idx_v[k]), 32'd0);
      chk_val($sformatf("rst_none[%0d]", k), 32'(out_none_v[k]), 32'd0);
      chk_val($sformatf("rst_ptr[%0d]", k), 32'(ptr_v[k]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic grant at ptr=0 with latency check
    send(0, 1024'(8'b1010_0100));
    check_latency(0);
    drain(0);

    // Loaded pointer, wrap and exact hit
    set_ptr(0, 5);
    send(0, 1024'(8'b0000_1001));
    send(0, 1024'(8'b0110_0000));
    drain(0);

    // Round-robin auto-advance, back-to-back all-ones beats
    set_ptr(0, 0);
    cfg_auto_v[0] = 1'b1;
    for (int b = 0; b < 10; b++) send(0, 1024'(8'hFF));
    drain(0);

    // All-zero vector leaves the pointer alone, then a downstream stall
    send(0, '0);
    drain(0);
    out_ready_v[0] = 1'b0;
    send(0, 1024'(8'h10));
    send(0, 1024'(8'h03));
    in_valid_v[0] = 1'b1;
    in_req_v[0]   = 1024'(8'h80);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_val("stall_in_ready[0]", 32'(in_ready_v[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready_v[0] = 1'b1;
    wait_accept(0);
    drain(0);
    cfg_auto_v[0] = 1'b0;

    // Wide vector: pointer near the top, then wrap of the pointer itself
    set_ptr(1, 1000);
    r       = '0;
    r[3]    = 1'b1;
    r[999]  = 1'b1;
    r[1023] = 1'b1;
    send(1, r);
    drain(1);
    set_ptr(1, 1023);
    cfg_auto_v[1] = 1'b1;
    send(1, '1);
    drain(1);
    chk_val("ptr_wrap[1]", 32'(ptr_v[1]), 32'd0);
    send(1, '1);
    drain(1);
    cfg_auto_v[1] = 1'b0;

    // Non-power-of-2 width with an out-of-range pointer
    set_ptr(2, 7);
    send(2, 1024'(6'b10_0010));
    send(2, 1024'(6'b11_1111));
    drain(2);

    // Reset with two results in flight
    set_ptr(2, 3);
    send(2, 1024'(6'b00_0110));
    send(2, 1024'(6'b11_0000));
    rst = 1'b1;
    #1;
    chk_val("rst_mid_valid[2]", 32'(out_valid_v[2]), 32'd0);
    chk_val("rst_mid_ptr[2]", 32'(ptr_v[2]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_val("post_rst_valid[2]", 32'(out_valid_v[2]), 32'd0);
    @(posedge clk);
    #1;
    send(2, 1024'(6'b00_1000));
    check_latency(2);
    drain(2);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
